// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: register map, ctrl bit positions, widths.
package pwm_pkg;

  localparam int unsigned MAX_CHANNELS = 32;
  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned PRESC_W      = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT0 = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM0 = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 8'h08;
  localparam logic [ADDR_W-1:0] ADDR_PRESC   = 8'h09;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD  = 8'h0A;
  localparam logic [ADDR_W-1:0] ADDR_DUTY0   = 8'h20;

  localparam int unsigned CTRL_RUN_BIT    = 0;
  localparam int unsigned CTRL_CENTER_BIT = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Register write bus into the PWM block.
interface pwm_multi_channel_if;
  import pwm_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter (edge or up/down), direction,
// the duty-load strobe and the registered period_start pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               center_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [CNT_W-1:0]   period_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               load_c_o,
  output logic               period_start_o
);

  logic [PRESC_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               run_prev_q;
  logic               ps_q, ps_d;
  logic               tick;
  logic               wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      run_prev_q <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      run_prev_q <= run_i;
      ps_q       <= ps_d;
    end
  end

  // A wrap is any tick that lands the counter on 0 at the start of a new period.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    tick  = 1'b0;
    wrap  = 1'b0;
    if (!run_i) begin
      pre_d = '0;
      cnt_d = '0;
      dir_d = DIR_UP;
    end else begin
      tick  = (pre_q >= presc_i);
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (cnt_q > period_i) begin
          cnt_d = '0;
          dir_d = DIR_UP;
          wrap  = 1'b1;
        end else if (center_i && (dir_q == DIR_DOWN || cnt_q == period_i)) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            dir_d = DIR_DOWN;
          end
        end else if (cnt_q == period_i) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    ps_d = wrap | (run_i & ~run_prev_q);
  end

  assign cnt_o          = cnt_q;
  assign load_c_o       = wrap;
  assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: register file, shadowed duty and per-channel compare.
// Optional macro PWM_CENTER_ALIGNED_EN enables up/down (center-aligned) counting.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_multi_channel_if.slave  bus,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  logic [CHANNELS-1:0] en_out_q, en_out_d;
  logic [CHANNELS-1:0] en_pwm_q, en_pwm_d;
  logic                run_q, run_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    duty_sh_q  [CHANNELS];
  logic [CNT_W-1:0]    duty_sh_d  [CHANNELS];
  logic [CNT_W-1:0]    duty_act_q [CHANNELS];
  logic [CNT_W-1:0]    duty_act_d [CHANNELS];
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CNT_W-1:0]    cnt;
  logic                load_c;
  logic                center;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q   <= '0;
      en_pwm_q   <= '0;
      run_q      <= 1'b0;
      presc_q    <= '0;
      period_q   <= '1;
      duty_sh_q  <= '{default: '0};
      duty_act_q <= '{default: '0};
      out_q      <= '0;
    end else begin
      en_out_q   <= en_out_d;
      en_pwm_q   <= en_pwm_d;
      run_q      <= run_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      out_q      <= out_d;
    end
  end

  // Register writes; only addresses of existing channels are decoded.
  always_comb begin
    en_out_d  = en_out_q;
    en_pwm_d  = en_pwm_q;
    run_d     = run_q;
    presc_d   = presc_q;
    period_d  = period_q;
    duty_sh_d = duty_sh_q;
    if (bus.wr_en) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (bus.wr_addr == ADDR_EN_OUT0 + 8'(i / 8)) en_out_d[i] = bus.wr_data[3'(i % 8)];
        if (bus.wr_addr == ADDR_EN_PWM0 + 8'(i / 8)) en_pwm_d[i] = bus.wr_data[3'(i % 8)];
        if (bus.wr_addr == ADDR_DUTY0 + 8'(i))       duty_sh_d[i] = bus.wr_data[CNT_W-1:0];
      end
      if (bus.wr_addr == ADDR_CTRL)   run_d    = bus.wr_data[CTRL_RUN_BIT];
      if (bus.wr_addr == ADDR_PRESC)  presc_d  = bus.wr_data;
      if (bus.wr_addr == ADDR_PERIOD) period_d = bus.wr_data[CNT_W-1:0];
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  logic center_q, center_d;

  always_comb begin
    center_d = center_q;
    if (bus.wr_en && bus.wr_addr == ADDR_CTRL) center_d = bus.wr_data[CTRL_CENTER_BIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) center_q <= 1'b0;
    else        center_q <= center_d;
  end

  assign center = center_q;
`else
  assign center = 1'b0;
`endif

  pwm_timebase #(
    .CNT_W (CNT_W)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_i          (run_q),
    .center_i       (center),
    .presc_i        (presc_q),
    .period_i       (period_q),
    .cnt_o          (cnt),
    .load_c_o       (load_c),
    .period_start_o (period_start)
  );

  // Active duty follows the shadow while stopped, otherwise only at the period wrap.
  always_comb begin
    duty_act_d = duty_act_q;
    out_d      = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (!run_q || load_c) duty_act_d[i] = duty_sh_q[i];
      out_d[i] = en_out_q[i] & (~en_pwm_q[i] | (cnt < duty_act_q[i]));
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed, table-driven bench for pwm_multi_channel (CHANNELS=16, CNT_W=8).
module tb_pwm_multi_channel;

  localparam int unsigned CH = 16;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] out;
  logic          period_start;

  pwm_multi_channel_if bus_if ();

  pwm_multi_channel #(
    .CHANNELS (CH),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .out          (out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int presc;
    int period;
    int duty;
    int win;
    int exp_hi3;
    int exp_ps;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int hi_cnt [CH];
  int ps_cnt;
  int other_cnt;
  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on a falling edge; the write is captured at the next rising edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    @(negedge clk);
    bus_if.wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (period_start) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < int'(CH); c++) hi_cnt[c] = 0;
    ps_cnt    = 0;
    other_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < int'(CH); c++) hi_cnt[c] += int'(out[c]);
      ps_cnt += int'(period_start);
    end
    for (int c = 0; c < int'(CH); c++)
      if (c != 3 && c != 5 && c != 6 && c != 7) other_cnt += hi_cnt[c];
  endtask

  task automatic start(input int presc, input int period, input int duty, input logic [7:0] ctrl);
    wr(8'h08, 8'h00);
    wr(8'h09, 8'(presc));
    wr(8'h0A, 8'(period));
    wr(8'h23, 8'(duty));
    wr(8'h08, ctrl);
    wait_ps("sync_a");
    wait_ps("sync_b");
  endtask

  initial begin
    int hi_a;
    int hi_b;

    tbl[0] = '{presc: 0, period: 9, duty: 4,  win: 20, exp_hi3: 8,  exp_ps: 2};
    tbl[1] = '{presc: 3, period: 4, duty: 2,  win: 40, exp_hi3: 16, exp_ps: 2};
    tbl[2] = '{presc: 0, period: 9, duty: 0,  win: 20, exp_hi3: 0,  exp_ps: 2};
    tbl[3] = '{presc: 0, period: 9, duty: 12, win: 20, exp_hi3: 20, exp_ps: 2};
    tbl[4] = '{presc: 0, period: 9, duty: 10, win: 20, exp_hi3: 20, exp_ps: 2};
    tbl[5] = '{presc: 0, period: 0, duty: 1,  win: 10, exp_hi3: 10, exp_ps: 10};
    tbl[6] = '{presc: 1, period: 0, duty: 1,  win: 10, exp_hi3: 10, exp_ps: 5};
    tbl[7] = '{presc: 0, period: 3, duty: 2,  win: 8,  exp_hi3: 4,  exp_ps: 2};

    rst_n          = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;
    repeat (2) @(negedge clk);
    check("reset_out", int'(out), 0);
    check("reset_ps", int'(period_start), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ch3 PWM, ch4 duty but disabled, ch5 forced high, ch6 duty 0, ch7 duty above period.
    wr(8'h00, 8'hE8);
    wr(8'h04, 8'hC8);
    wr(8'h24, 8'd5);
    wr(8'h26, 8'd0);
    wr(8'h27, 8'd12);
    wr(8'h30, 8'hFF);
    wr(8'h03, 8'hFF);
    wr(8'h07, 8'hFF);
    wr(8'h10, 8'hFF);

    for (int v = 0; v < 8; v++) begin
      start(tbl[v].presc, tbl[v].period, tbl[v].duty, 8'h01);
      measure(tbl[v].win);
      check($sformatf("v%0d_out3_high", v), hi_cnt[3], tbl[v].exp_hi3);
      check($sformatf("v%0d_period_start", v), ps_cnt, tbl[v].exp_ps);
      check($sformatf("v%0d_out5_force", v), hi_cnt[5], tbl[v].win);
      check($sformatf("v%0d_out6_duty0", v), hi_cnt[6], 0);
      check($sformatf("v%0d_out7_over", v), hi_cnt[7], tbl[v].win);
      check($sformatf("v%0d_other_off", v), other_cnt, 0);
    end

    // Mid-period shadow write: current period keeps duty 4, next one uses 8.
    start(0, 9, 4, 8'h01);
    hi_a = 0;
    hi_b = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 10) hi_a += int'(out[3]);
      else         hi_b += int'(out[3]);
      if (k == 2) begin
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = 8'h23;
        bus_if.wr_data = 8'd8;
      end else begin
        bus_if.wr_en = 1'b0;
      end
    end
    check("shadow_cur_period", hi_a, 4);
    check("shadow_next_period", hi_b, 8);

`ifdef PWM_CENTER_ALIGNED_EN
    start(0, 4, 2, 8'h03);
    measure(16);
    check("center_out3_high", hi_cnt[3], 6);
    check("center_period_start", ps_cnt, 2);
`else
    start(0, 4, 2, 8'h03);
    measure(10);
    check("nocenter_out3_high", hi_cnt[3], 4);
    check("nocenter_period_start", ps_cnt, 2);
`endif

    // Asynchronous reset mid-run clears outputs without waiting for a clock.
    @(negedge clk);
    check("pre_reset_out5", int'(out[5]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", int'(out), 0);
    check("async_reset_ps", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(3);
    check("post_reset_out5", hi_cnt[5], 0);
    check("post_reset_ps", ps_cnt, 0);

    // Period left at its reset value of 255.
    wr(8'h00, 8'h08);
    wr(8'h04, 8'h08);
    wr(8'h23, 8'd128);
    wr(8'h08, 8'h01);
    wait_ps("rst_sync_a");
    wait_ps("rst_sync_b");
    measure(256);
    check("reset_period_out3", hi_cnt[3], 128);
    check("reset_period_ps", ps_cnt, 1);
    check("reset_period_out5", hi_cnt[5], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
